// File: rtl/uart_rx_frame_parser_pkg.sv
// Shared types and defaults for the UART receive frame parser.
package uart_rx_frame_parser_pkg;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM
  } parser_state_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_CSUM_ERR = 3'd1,
    ST_LEN_ERR  = 3'd2,
    ST_TIMEOUT  = 3'd3,
    ST_RX_ERR   = 3'd4
  } status_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT      = 8'hA5;
  localparam int         MAX_LEN_DEFAULT        = 64;
  localparam int         TIMEOUT_CYCLES_DEFAULT = 48000;

  // A length byte is usable only when it names at least one payload byte
  // and no more than the largest frame the parser accepts.
  function automatic logic lenIsLegal(input logic [7:0] len, input logic [7:0] maxLen);
    return (len != 8'd0) && (len <= maxLen);
  endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Bundles the RX FIFO side, the receiver error strobe, the payload stream
// and the status report of the frame parser.
interface uart_rx_frame_parser_if;

  logic [7:0] i_fifo_data;
  logic       i_fifo_empty;
  logic       i_rx_err;
  logic       o_fifo_rd_en;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_sop;
  logic       o_eop;
  logic       o_status_vld;
  logic [2:0] o_status;

  // The parser itself.
  modport master (
    input  i_fifo_data, i_fifo_empty, i_rx_err, i_ready,
    output o_fifo_rd_en, o_data, o_valid, o_sop, o_eop, o_status_vld, o_status
  );

  // The surroundings: FIFO, receiver and payload consumer.
  modport slave (
    output i_fifo_data, i_fifo_empty, i_rx_err, i_ready,
    input  o_fifo_rd_en, o_data, o_valid, o_sop, o_eop, o_status_vld, o_status
  );

endinterface

// File: rtl/uart_rx_frame_parser_timer.sv
// Inter-byte idle timer. Counts cycles while running and not held, and
// pulses expired_o on the cycle the count sits at its last value. A clear
// always beats an expiry in the same cycle.
module uart_frame_timer #(
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic run_i,
  input  logic hold_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count and expiry decision; clear has priority over everything.
  always_comb begin
    count_d   = count_q;
    expired_o = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (run_i && !hold_i) begin
      if (count_q == LAST) begin
        expired_o = 1'b1;
        count_d   = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Drains the RX FIFO, hunts for SYNC, checks LEN, streams PAYLOAD bytes with
// sop/eop and verifies the XOR checksum. Every frame end and every abort
// produces a one-cycle status pulse.
module uart_rx_frame_parser
  import uart_rx_frame_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic                    clk,
  input logic                    rst_n,
  uart_rx_frame_parser_if.master bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parser_state_e state_q, state_d;
  logic          rdPend_q, rdPend_d;
  logic [7:0]    remain_q, remain_d;
  logic [7:0]    chk_q, chk_d;
  logic          first_q, first_d;
  logic [7:0]    dataOut_q, dataOut_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          statusVld_q, statusVld_d;
  status_e       status_q, status_d;

  logic       capture;
  logic [7:0] capByte;
  logic       outStall;
  logic       needByte;
  logic       fetch;
  logic       abort;
  logic       timerRun;
  logic       timerClr;
  logic       timerExpired;

  // A byte arrives the cycle after its read strobe. A pending payload byte
  // that is not being accepted stalls both fetching and the idle timer.
  // Nothing is fetched on an abort cycle so no byte is left in flight.
  always_comb begin
    capture  = rdPend_q;
    capByte  = bus.i_fifo_data;
    outStall = valid_q && !bus.i_ready;
    timerRun = (state_q != HUNT);
    timerClr = capture || (state_q == HUNT);
    abort    = (state_q != HUNT) && (bus.i_rx_err || timerExpired);
    needByte = (state_q != PAYLOAD) || !outStall;
    fetch    = rst_n && needByte && !rdPend_q && !bus.i_fifo_empty && !abort;
  end

  uart_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (timerClr),
    .run_i    (timerRun),
    .hold_i   (outStall),
    .expired_o(timerExpired)
  );

  // Frame FSM, checksum, remaining count and output register; an abort
  // overrides any byte captured in the same cycle.
  always_comb begin
    state_d     = state_q;
    rdPend_d    = fetch;
    remain_d    = remain_q;
    chk_d       = chk_q;
    first_d     = first_q;
    dataOut_d   = dataOut_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    statusVld_d = 1'b0;
    status_d    = status_q;

    if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end

    if (abort) begin
      state_d     = HUNT;
      valid_d     = 1'b0;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      statusVld_d = 1'b1;
      status_d    = bus.i_rx_err ? ST_RX_ERR : ST_TIMEOUT;
    end else if (capture) begin
      case (state_q)
        HUNT: begin
          if (capByte == SYNC_BYTE) state_d = LEN;
        end
        LEN: begin
          if (lenIsLegal(capByte, MAX_LEN_B)) begin
            remain_d = capByte;
            chk_d    = capByte;
            first_d  = 1'b1;
            state_d  = PAYLOAD;
          end else begin
            statusVld_d = 1'b1;
            status_d    = ST_LEN_ERR;
            state_d     = HUNT;
          end
        end
        PAYLOAD: begin
          dataOut_d = capByte;
          valid_d   = 1'b1;
          sop_d     = first_q;
          eop_d     = (remain_q == 8'd1);
          first_d   = 1'b0;
          chk_d     = chk_q ^ capByte;
          remain_d  = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = CSUM;
        end
        CSUM: begin
          statusVld_d = 1'b1;
          status_d    = (capByte == chk_q) ? ST_OK : ST_CSUM_ERR;
          state_d     = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      rdPend_q    <= 1'b0;
      remain_q    <= 8'd0;
      chk_q       <= 8'd0;
      first_q     <= 1'b0;
      dataOut_q   <= 8'd0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      statusVld_q <= 1'b0;
      status_q    <= ST_OK;
    end else begin
      state_q     <= state_d;
      rdPend_q    <= rdPend_d;
      remain_q    <= remain_d;
      chk_q       <= chk_d;
      first_q     <= first_d;
      dataOut_q   <= dataOut_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      statusVld_q <= statusVld_d;
      status_q    <= status_d;
    end
  end

  assign bus.o_fifo_rd_en = fetch;
  assign bus.o_data       = dataOut_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_sop        = sop_q;
  assign bus.o_eop        = eop_q;
  assign bus.o_status_vld = statusVld_q;
  assign bus.o_status     = status_q;

endmodule
